// File: rtl/alu_mdu_arbiter.sv
// Shares the EX-stage ALU between the pipeline and a shift-and-add MULTU sequencer.
// EX always wins the ALU; the multiplier only issues its adds in idle ALU cycles.
module alu_mdu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic [2:0]       ex_ctr,
  input  logic             mdu_start,
  input  logic [WIDTH-1:0] mdu_a,
  input  logic [WIDTH-1:0] mdu_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result,
  output logic             ex_res_valid,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exrv_q, busy_q, done_q;
  logic             last_d, carry_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    last_d  = (cnt_d == CNT_W'(WIDTH));
    // The ALU has no carry-out; an unsigned add overflowed iff the sum wrapped below hi.
    carry_d = (alu_result < hi_q);
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = 3'b000;
    if (ex_valid) begin
      alu_a   = ex_a;
      alu_b   = ex_b;
      alu_ctr = ex_ctr;
    end else if (state_q == S_ISSUE && lo_q[0]) begin
      alu_a   = hi_q;
      alu_b   = mcand_q;
      alu_ctr = 3'b000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      exrv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      exrv_q <= ex_valid;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mdu_start) begin
            mcand_q <= mdu_a;
            lo_q    <= mdu_b;
            hi_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!lo_q[0]) begin
            hi_q  <= hi_q >> 1;
            lo_q  <= {hi_q[0], lo_q[WIDTH-1:1]};
            cnt_q <= cnt_d;
            if (last_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (!ex_valid) begin
            // Add goes to the ALU this cycle; its registered sum is consumed in WAIT.
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          hi_q  <= {carry_d, alu_result[WIDTH-1:1]};
          lo_q  <= {alu_result[0], lo_q[WIDTH-1:1]};
          cnt_q <= cnt_d;
          if (last_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex_res_valid = exrv_q;
  assign mdu_busy     = busy_q;
  assign mdu_done     = done_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule
